// File: rtl/vga_pkg.sv
// Shared constants and types for the AXI4-Lite video-memory write buffer.
package vga_pkg;

  // Status word layout returned on every AXI read
  localparam int STAT_FULL_BIT  = 8;
  localparam int STAT_EMPTY_BIT = 9;
  localparam logic [15:0] STAT_ID = 16'h0B0F;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // The frame-buffer address space fits in 32 bits
  localparam int VMEM_ADDR_W = 32;

  // One queued pixel write
  typedef struct packed {
    logic [VMEM_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [3:0]             strb;
  } vmem_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a ptr+1-bit level counter. Storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Push is refused when full, pop when empty; full is the pre-pop count
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];

  // Storage write; contents after reset are don't-care
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axilite_vmem_write_buffer.sv
// AXI4-Lite slave that pairs AW/W beats, queues them, and drains them as a
// valid/ready pixel-write stream. Reads return a queue status word.
//
// Handshakes: a transfer happens on any clock edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge.
module axilite_vmem_write_buffer
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [31:0]           axi_wdata,
  input  logic [3:0]            axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [31:0]           axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  wdata_en,
  output logic [ADDR_WIDTH-1:0] wdata_addr,
  output logic [31:0]           wdata,
  output logic [3:0]            wdata_byte_en,
  input  logic                  wdata_ready
);

  logic                   aw_full;
  logic                   w_full;
  logic [ADDR_WIDTH-1:0]  aw_addr_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   ar_hs;
  logic                   push;
  logic                   pop;
  vmem_wr_t               wr_in;
  vmem_wr_t               wr_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LEVEL_WIDTH-1:0] fifo_level;
  logic [31:0]            status;
  logic                   unused_araddr;

  // Every address returns the same status word
  assign unused_araddr = ^axi_araddr;

  assign axi_awready = !aw_full;
  assign axi_wready  = !w_full;
  assign axi_arready = !axi_rvalid;
  assign axi_bresp   = AXI_RESP_OKAY;
  assign axi_rresp   = AXI_RESP_OKAY;

  assign aw_hs = axi_awvalid & !aw_full;
  assign w_hs  = axi_wvalid & !w_full;
  assign ar_hs = axi_arvalid & !axi_rvalid;

  // A beat arriving this cycle counts as held, so a same-cycle AW+W pair is
  // queued on the handshake edge itself.
  assign push = (aw_full | aw_hs) & (w_full | w_hs) & !fifo_full &
                (!axi_bvalid | axi_bready);
  assign pop  = wdata_en & wdata_ready;

  // Build the queue entry from holding registers or the live channel
  always_comb begin
    wr_in      = '0;
    wr_in.addr = VMEM_ADDR_W'(aw_full ? aw_addr_q : axi_awaddr) & ~VMEM_ADDR_W'(3);
    wr_in.data = w_full ? w_data_q : axi_wdata;
    wr_in.strb = w_full ? w_strb_q : axi_wstrb;
  end

  // Assemble the status word from the current queue state
  always_comb begin
    status                  = '0;
    status[LEVEL_WIDTH-1:0] = fifo_level;
    status[STAT_FULL_BIT]   = fifo_full;
    status[STAT_EMPTY_BIT]  = fifo_empty;
    status[31:16]           = STAT_ID;
  end

  // AW and W holding registers; a push empties both
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (push) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end
    end
  end

  // Write response: one B per queued entry, held until accepted
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn)     axi_bvalid <= 1'b0;
    else if (push)       axi_bvalid <= 1'b1;
    else if (axi_bready) axi_bvalid <= 1'b0;
  end

  // Read channel: latch status on AR, hold until R is accepted
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
    end else if (ar_hs) begin
      axi_rvalid <= 1'b1;
      axi_rdata  <= status;
    end else if (axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(vmem_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_clk),
    .rst_n (axi_resetn),
    .push  (push),
    .din   (wr_in),
    .pop   (pop),
    .dout  (wr_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign wdata_en      = !fifo_empty;
  assign wdata_addr    = ADDR_WIDTH'(wr_head.addr);
  assign wdata         = wr_head.data;
  assign wdata_byte_en = wr_head.strb;

endmodule

// File: tb/tb_axilite_vmem_write_buffer.sv
// Directed bench for axilite_vmem_write_buffer with a scoreboard monitor.
module tb_axilite_vmem_write_buffer;

  logic        axi_clk = 1'b0;
  logic        axi_resetn;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        wdata_en;
  logic [31:0] wdata_addr;
  logic [31:0] wdata;
  logic [3:0]  wdata_byte_en;
  logic        wdata_ready;

  logic [67:0] exp_q[$];
  logic [31:0] rd_exp_q[$];
  int total = 0;
  int bad = 0;
  int b_count = 0;
  int b_exp = 0;

  // Directed vectors: raw address, expected word address, data, strobe
  logic [31:0] t3_addr [5] = '{32'h3001, 32'h3012, 32'h3023, 32'h3030, 32'h3047};
  logic [31:0] t3_eadr [5] = '{32'h3000, 32'h3010, 32'h3020, 32'h3030, 32'h3044};
  logic [31:0] t3_data [5] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
  logic [3:0]  t3_strb [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

  // Clock / reset
  always #5 axi_clk = ~axi_clk;

  axilite_vmem_write_buffer dut (
    .axi_clk       (axi_clk),
    .axi_resetn    (axi_resetn),
    .axi_awaddr    (axi_awaddr),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_bresp     (axi_bresp),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_araddr    (axi_araddr),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rresp     (axi_rresp),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready),
    .wdata_en      (wdata_en),
    .wdata_addr    (wdata_addr),
    .wdata         (wdata),
    .wdata_byte_en (wdata_byte_en),
    .wdata_ready   (wdata_ready)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  // Driver tasks: start at posedge+1, return at handshake edge+1
  task automatic aw_send(input logic [31:0] a);
    int n = 0;
    axi_awaddr  = a;
    axi_awvalid = 1'b1;
    @(negedge axi_clk);
    while (!axi_awready && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    chk("aw_wait", 68'(axi_awready), 68'(1));
    @(posedge axi_clk);
    #1 axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi_wdata  = d;
    axi_wstrb  = s;
    axi_wvalid = 1'b1;
    @(negedge axi_clk);
    while (!axi_wready && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    chk("w_wait", 68'(axi_wready), 68'(1));
    @(posedge axi_clk);
    #1 axi_wvalid = 1'b0;
  endtask

  task automatic wr_pair(input logic [31:0] a, input logic [31:0] ea,
                         input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({ea, d, s});
    b_exp++;
    fork
      aw_send(a);
      w_send(d, s);
    join
  endtask

  task automatic rd_status(input logic [31:0] exp);
    int n = 0;
    rd_exp_q.push_back(exp);
    axi_araddr  = 32'h10;
    axi_arvalid = 1'b1;
    @(negedge axi_clk);
    while (!axi_arready && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    chk("ar_wait", 68'(axi_arready), 68'(1));
    @(posedge axi_clk);
    #1 axi_arvalid = 1'b0;
    cyc(1);
  endtask

  // Scoreboard monitor: pops expected entries as the DUT presents them
  task automatic monitor();
    forever begin
      @(negedge axi_clk);
      if (axi_resetn) begin
        if (wdata_en && wdata_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %h expected none", {wdata_addr, wdata, wdata_byte_en});
          end else begin
            chk("pop_entry", {wdata_addr, wdata, wdata_byte_en}, exp_q.pop_front());
          end
        end
        if (axi_rvalid && axi_rready) begin
          if (rd_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got %h expected none", axi_rdata);
          end else begin
            chk("rd_status", 68'(axi_rdata), 68'(rd_exp_q.pop_front()));
          end
        end
        if (axi_bvalid && axi_bready) b_count++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    axi_resetn  = 1'b0;
    axi_awaddr  = '0;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b1;
    axi_araddr  = '0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b1;
    wdata_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    #12;
    chk("rst_awready", 68'(axi_awready), 68'(1));
    chk("rst_wready", 68'(axi_wready), 68'(1));
    chk("rst_arready", 68'(axi_arready), 68'(1));
    chk("rst_bvalid", 68'(axi_bvalid), 68'(0));
    chk("rst_rvalid", 68'(axi_rvalid), 68'(0));
    chk("rst_rdata", 68'(axi_rdata), 68'(0));
    chk("rst_wdata_en", 68'(wdata_en), 68'(0));
    chk("rst_resp", 68'({axi_bresp, axi_rresp}), 68'(0));
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk) axi_resetn = 1'b1;
    cyc(1);

    // Same-cycle AW + W: visible on the pixel port one cycle later
    wr_pair(32'h0000_1006, 32'h0000_1004, 32'hDEADBEEF, 4'b1100);
    chk("t1_bvalid", 68'(axi_bvalid), 68'(1));
    chk("t1_wdata_en", 68'(wdata_en), 68'(1));
    chk("t1_addr", 68'(wdata_addr), 68'(32'h1004));
    chk("t1_data", 68'(wdata), 68'(32'hDEADBEEF));
    chk("t1_strb", 68'(wdata_byte_en), 68'(4'b1100));
    cyc(1);
    chk("t1_en_after", 68'(wdata_en), 68'(0));
    chk("t1_bvalid_after", 68'(axi_bvalid), 68'(0));

    // W three cycles ahead of AW
    exp_q.push_back({32'h2000, 32'h12345678, 4'b0011});
    b_exp++;
    w_send(32'h12345678, 4'b0011);
    ok = 1'b1;
    repeat (3) begin
      if (axi_wready !== 1'b0 || wdata_en !== 1'b0) ok = 1'b0;
      cyc(1);
    end
    chk("t2_w_held", 68'(ok), 68'(1));
    aw_send(32'h2003);
    chk("t2_bvalid", 68'(axi_bvalid), 68'(1));
    chk("t2_wdata_en", 68'(wdata_en), 68'(1));
    cyc(2);
    chk("t2_bcount", 68'(b_count), 68'(b_exp));

    // Back-pressure: 4 queued, 5th pair parked in holding registers
    wdata_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr_pair(t3_addr[i], t3_eadr[i], t3_data[i], t3_strb[i]);
    cyc(1);
    chk("t3_awready", 68'(axi_awready), 68'(0));
    chk("t3_wready", 68'(axi_wready), 68'(0));
    chk("t3_wdata_en", 68'(wdata_en), 68'(1));
    rd_status(32'h0B0F_0104);
    wdata_ready = 1'b1;
    cyc(8);
    chk("t3_drained", 68'(exp_q.size()), 68'(0));
    chk("t3_bcount", 68'(b_count), 68'(b_exp));

    // B held off: second pair waits in holding registers
    axi_bready = 1'b0;
    wr_pair(32'h4000, 32'h4000, 32'h11111111, 4'b1111);
    wr_pair(32'h400A, 32'h4008, 32'h22222222, 4'b0101);
    ok = 1'b1;
    repeat (10) begin
      if (axi_bvalid !== 1'b1 || axi_awready !== 1'b0 || wdata_en !== 1'b0) ok = 1'b0;
      cyc(1);
    end
    chk("t4_held", 68'(ok), 68'(1));
    axi_bready = 1'b1;
    cyc(1);
    chk("t4_bvalid", 68'(axi_bvalid), 68'(1));
    chk("t4_pushed", 68'(wdata_en), 68'(1));
    chk("t4_awready", 68'(axi_awready), 68'(1));
    cyc(2);
    chk("t4_bcount", 68'(b_count), 68'(b_exp));

    // Full FIFO with same-cycle pop: push stalls one cycle (4 -> 3 -> 4)
    wdata_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      wr_pair(32'h5000 + 32'(i * 4), 32'h5000 + 32'(i * 4), 32'hB0000000 + 32'(i), 4'b1111);
    cyc(1);
    wdata_ready = 1'b1;
    cyc(1);
    wdata_ready = 1'b0;
    chk("t5_stalled", 68'(axi_awready), 68'(0));
    chk("t5_no_b", 68'(axi_bvalid), 68'(0));
    rd_exp_q.push_back(32'h0B0F_0003);
    axi_arvalid = 1'b1;
    cyc(1);
    axi_arvalid = 1'b0;
    chk("t5_pushed", 68'(axi_awready), 68'(1));
    chk("t5_bvalid", 68'(axi_bvalid), 68'(1));
    cyc(1);
    rd_status(32'h0B0F_0104);
    wdata_ready = 1'b1;
    cyc(8);
    chk("t5_drained", 68'(exp_q.size()), 68'(0));

    // Reset with three queued writes drops them
    wdata_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      wr_pair(32'h6000 + 32'(i * 4), 32'h6000 + 32'(i * 4), 32'hC0000000 + 32'(i), 4'b1010);
    cyc(1);
    axi_resetn = 1'b0;
    #2;
    chk("t6_awready", 68'(axi_awready), 68'(1));
    chk("t6_wready", 68'(axi_wready), 68'(1));
    chk("t6_arready", 68'(axi_arready), 68'(1));
    chk("t6_wdata_en", 68'(wdata_en), 68'(0));
    chk("t6_bvalid", 68'(axi_bvalid), 68'(0));
    exp_q.delete();
    @(negedge axi_clk) axi_resetn = 1'b1;
    cyc(1);
    rd_status(32'h0B0F_0200);
    wdata_ready = 1'b1;
    cyc(4);

    chk("end_exp_q", 68'(exp_q.size()), 68'(0));
    chk("end_rd_q", 68'(rd_exp_q.size()), 68'(0));
    chk("end_bcount", 68'(b_count), 68'(b_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axilite_vmem_write_buffer.md
# axilite_vmem_write_buffer

AXI4-Lite slave front end for the VGA frame-buffer path. It accepts CPU writes on independent AW/W channels and pairs them. Each pair is queued in a small FIFO, and the FIFO drains as a valid/ready pixel-write stream (`wdata_en`, `wdata_addr`, `wdata`, `wdata_byte_en`, `wdata_ready`) into the VGA controller's video-memory write port. Reads return a status word, so software can poll the queue level.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of AXI addresses and of `wdata_addr`.
- `FIFO_DEPTH`, 4: number of queued writes; must be a power of two, at least 2.
- `LEVEL_WIDTH`, 3: equals log2(`FIFO_DEPTH`)+1.

Ports:
- Clock and reset are fixed: one clock `axi_clk`; reset `axi_resetn` is asynchronous and active-low.
- `axi_clk` in 1: single clock for all logic.
- `axi_resetn` in 1: asynchronous active-low reset.
- `axi_awaddr` in `ADDR_WIDTH`; `axi_awvalid` in 1; `axi_awready` out 1.
- `axi_wdata` in 32; `axi_wstrb` in 4; `axi_wvalid` in 1; `axi_wready` out 1.
- `axi_bresp` out 2; `axi_bvalid` out 1; `axi_bready` in 1.
- `axi_araddr` in `ADDR_WIDTH`; `axi_arvalid` in 1; `axi_arready` out 1.
- `axi_rdata` out 32; `axi_rresp` out 2; `axi_rvalid` out 1; `axi_rready` in 1.
- `wdata_en` out 1: head of queue valid.
- `wdata_addr` out `ADDR_WIDTH`: word address, bits [1:0] forced to 0.
- `wdata` out 32; `wdata_byte_en` out 4.
- `wdata_ready` in 1: downstream accepts the head entry. Tie to 1 for a controller without back-pressure.

## Operation
- AW holding register `aw_full`; W holding register `w_full`.
  - `axi_awready` = !`aw_full`.
  - `axi_wready` = !`w_full`.
  - Each channel is accepted independently, in either order or in the same cycle.
- Push condition: `aw_full` & `w_full` & !fifo_full & (!`axi_bvalid` | `axi_bready`).
- On push:
  - Enqueue {awaddr & ~3, wdata, wstrb}.
  - Clear both holding registers.
  - Set `axi_bvalid`.
- `axi_bvalid` stays high until `axi_bready`. `axi_bresp` is always 2'b00.
- Pop when `wdata_en` & `wdata_ready`. Outputs show the head entry combinationally from FIFO storage.
- Full FIFO blocks push even if a pop occurs in the same cycle (push sees the pre-pop count). Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Entries with `wstrb`=0 are still queued and forwarded unchanged.
- Read channel:
  - `axi_arready` = !`axi_rvalid`.
  - On an AR handshake, latch the status word and set `axi_rvalid`. Any address returns the status word.
  - `axi_rresp` is always 2'b00.
  - Status word: [`LEVEL_WIDTH`-1:0] = FIFO level, [8] = full, [9] = empty, [31:16] = 16'h0B0F (identification), all other bits 0.
  - `axi_rvalid` clears on `axi_rready`.
- Reads and writes proceed concurrently and independently.

## Timing
- Reset (async assert, sync release) applies to all state; FIFO storage contents are don't-care. Output values during and after reset:
  - `axi_awready`=1, `axi_wready`=1, `axi_arready`=1.
  - `axi_bvalid`=0, `axi_rvalid`=0, `axi_rdata`=0, `wdata_en`=0.
  - `axi_bresp` and `axi_rresp` are always 0.
- Write latency: AW and W both handshake in cycle 0 with an empty FIFO and idle B. In cycle 1, `axi_bvalid`=1 and `wdata_en`=1 with the entry on the outputs.
- Read latency: AR handshake in cycle 0; `axi_rvalid`=1 in cycle 1. The status reflects state registered at the end of cycle 0.
- If `axi_bready` stays low, the next completed pair waits in the holding registers. At most one W beat beyond the queue can be absorbed.
- Reset asserted mid-transaction: any queued and held writes are dropped; no B response is issued for them.

## Structure
- Package `vga_pkg` holds:
  - status-word bit positions (`STAT_FULL_BIT`=8, `STAT_EMPTY_BIT`=9);
  - ID constant 16'h0B0F;
  - `AXI_RESP_OKAY`=2'b00;
  - a packed struct `vmem_wr_t` {addr, data, strb}.
- One sub-module `sync_fifo`: parameterised width and depth, ptr+1-bit level counter, async active-low reset, outputs `full`/`empty`/`level`.

## Test plan
- Same-cycle AW (0x0000_1006) + W (0xDEADBEEF, strb 4'b1100), `wdata_ready`=1 → cycle 1: `axi_bvalid`=1, `wdata_en`=1, `wdata_addr`=0x1004, `wdata`=0xDEADBEEF, `wdata_byte_en`=4'b1100; cycle 2: `wdata_en`=0.
- W three cycles before AW, then AW → `axi_wready`=0 while waiting; one entry pushed the cycle after AW; exactly one B response.
- `wdata_ready`=0, 5 writes with `axi_bready`=1 → 4 accepted. The 5th pair sits in the holding registers with `axi_awready`=`axi_wready`=0. A status read returns level=4, bit8=1, bits[31:16]=0x0B0F. Release `wdata_ready` → 5 pops in order.
- `axi_bready` held low for 10 cycles after the first write → `axi_bvalid` stays 1; a second pair is held, not pushed. `axi_bready` pulse → second push on the next edge.
- Full FIFO with push and pop in the same cycle → push stalls one cycle; level goes 4→3→4.
- Assert `axi_resetn` low with 3 queued writes → all ready signals 1, `wdata_en`=0, `axi_bvalid`=0 immediately; after release, a status read gives level=0 and bit9=1.
